// File: rtl/prod_accumulator_pkg.sv
// ============================================================================
// Module   : prod_accumulator_pkg
// Purpose  : Shared constants for the product accumulator: FSM state
//            encoding, multiplier product width and default widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prod_accumulator_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    // Sign-magnitude product from the 12x12 multiplier
    localparam int c_PROD_W = 24;

    // Default widths
    localparam int c_ACC_W_DEF = 28;
    localparam int c_LEN_W_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/sm_to_tc.sv
// ============================================================================
// Module   : sm_to_tc
// Purpose  : Combinational sign-magnitude to two's-complement converter with
//            sign extension to a wider output. Negative zero maps to 0.
// Ports    : i_sm  [IN_W-1:0]  sign-magnitude input (MSB = sign)
//            o_tc  [OUT_W-1:0] two's-complement result
// Notes    : OUT_W must be >= IN_W so the magnitude plus sign always fits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_to_tc
    import prod_accumulator_pkg::*;
#(
    parameter int IN_W  = c_PROD_W,
    parameter int OUT_W = c_ACC_W_DEF
) (
    input  logic [IN_W-1:0]  i_sm,
    output logic [OUT_W-1:0] o_tc
);

    // Magnitude zero-extended to the output width; the extra headroom bit
    // guarantees the negated value cannot wrap.
    logic [OUT_W-1:0] w_mag;

    assign w_mag = {{(OUT_W-IN_W+1){1'b0}}, i_sm[IN_W-2:0]};

    // Negating a zero magnitude yields zero, so -0 needs no special case.
    assign o_tc = i_sm[IN_W-1] ? (-w_mag) : w_mag;

endmodule

`default_nettype wire

// File: rtl/prod_accumulator.sv
// ============================================================================
// Module   : prod_accumulator
// Purpose  : Accumulates a run of len sign-magnitude products into a
//            saturating signed accumulator and holds the result until a
//            valid/ready handshake.
// Ports    : clk, reset (async, active-high)
//            start, len        - run request, sampled only in IDLE
//            prod_valid, prod  - one product per cycle, no backpressure
//            acc_out           - running accumulator (result when acc_valid)
//            acc_valid, acc_ready - result handshake
//            busy              - high in ACCUM and HOLD
//            sat_flag          - sticky per run, any saturated addition
//            drop_flag         - product arrived outside ACCUM
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prod_accumulator
    import prod_accumulator_pkg::*;
#(
    parameter int ACC_W = c_ACC_W_DEF,
    parameter int LEN_W = c_LEN_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                prod_valid,
    input  logic [c_PROD_W-1:0] prod,
    output logic [ACC_W-1:0]    acc_out,
    output logic                acc_valid,
    input  logic                acc_ready,
    output logic                busy,
    output logic                sat_flag,
    output logic                drop_flag
);

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_busy;
    logic             r_sat;
    logic             r_drop;

    logic [ACC_W-1:0] w_prod;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_next_acc;

    sm_to_tc #(
        .IN_W  (c_PROD_W),
        .OUT_W (ACC_W)
    ) u_sm_to_tc (
        .i_sm (prod),
        .o_tc (w_prod)
    );

    // One extra bit of headroom: overflow shows up as the two top bits
    // disagreeing, and the top bit then gives the true sign of the sum.
    assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_prod[ACC_W-1], w_prod};
    assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_next_acc = w_sum[ACC_W-1:0];
        if (w_ovf) begin
            if (w_sum[ACC_W]) begin
                w_next_acc = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                w_next_acc = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_sat   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (prod_valid) begin
                        r_drop <= 1'b1;
                    end
                    // An accepted start opens a fresh run, so it clears the
                    // drop indication even if a stray product coincides.
                    if (start) begin
                        r_acc  <= '0;
                        r_sat  <= 1'b0;
                        r_drop <= 1'b0;
                        r_busy <= 1'b1;
                        r_cnt  <= len;
                        if (len == '0) begin
                            r_state <= c_ST_HOLD;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= c_ST_ACCUM;
                        end
                    end
                end

                c_ST_ACCUM: begin
                    if (prod_valid) begin
                        r_acc <= w_next_acc;
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (w_ovf) begin
                            r_sat <= 1'b1;
                        end
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= c_ST_HOLD;
                            r_valid <= 1'b1;
                        end
                    end
                end

                c_ST_HOLD: begin
                    if (prod_valid) begin
                        r_drop <= 1'b1;
                    end
                    // acc_valid is always high in HOLD, so ready alone
                    // completes the handshake.
                    if (acc_ready) begin
                        r_state <= c_ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign acc_out   = r_acc;
    assign acc_valid = r_valid;
    assign busy      = r_busy;
    assign sat_flag  = r_sat;
    assign drop_flag = r_drop;

endmodule

`default_nettype wire
